// File: rtl/uart_rx_arbiter.sv
// Round-robin arbiter sharing the UART receiver byte-read port (stb/ack/data) between NUM_REQ requesters.
// Define UART_RX_ARB_TIMEOUT_EN to add the downstream-ack timeout with late-ack drain and hold register.
module uart_rx_arbiter #(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned TIMEOUT_CLKS = 4096
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req_stb_i,
   output logic [NUM_REQ-1:0] req_ack_o,
   output logic [NUM_REQ-1:0] req_err_o,
   output logic [7:0]         req_data_o,
   output logic               rx_stb_o,
   input  logic               rx_ack_i,
   input  logic [7:0]         rx_data_i
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned DW = 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
`ifdef UART_RX_ARB_TIMEOUT_EN
   localparam logic [1:0] S_DRAIN = 2'd3;
   localparam int unsigned CW     = 16;
`endif

   if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CLKS > 65535) begin : g_bad_params
      $error("uart_rx_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CLKS below 65536");
   end

   // First set candidate at or above ptr, wrapping modulo NUM_REQ.
   function automatic logic [PW-1:0] f_rr_pick(input logic [NUM_REQ-1:0] cand,
                                                input logic [PW-1:0]      ptr);
      logic [PW-1:0] pick;
      logic [PW-1:0] idx_p;
      logic          found;
      int unsigned   idx;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx   = (32'(ptr) + k) % NUM_REQ;
         idx_p = PW'(idx);
         if (!found && cand[idx_p]) begin
            pick  = idx_p;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] idx);
      return (32'(idx) == NUM_REQ - 1) ? '0 : idx + PW'(1);
   endfunction

   function automatic logic [NUM_REQ-1:0] f_onehot(input logic [PW-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [NUM_REQ-1:0] r_pending;
   logic [NUM_REQ-1:0] w_pending_nxt;
   logic [PW-1:0]      r_rr_ptr;
   logic [PW-1:0]      w_rr_ptr_nxt;
   logic [PW-1:0]      r_gnt_idx;
   logic [PW-1:0]      w_gnt_idx_nxt;
   logic [NUM_REQ-1:0] r_ack;
   logic [NUM_REQ-1:0] w_ack_nxt;
   logic               r_rx_stb;
   logic               w_rx_stb_nxt;
   logic [DW-1:0]      r_data;
   logic [DW-1:0]      w_data_nxt;
   logic [NUM_REQ-1:0] w_cand;
   logic [PW-1:0]      w_win;
   logic [NUM_REQ-1:0] w_done;
`ifdef UART_RX_ARB_TIMEOUT_EN
   logic [NUM_REQ-1:0] r_err;
   logic [NUM_REQ-1:0] w_err_nxt;
   logic [CW-1:0]      r_tmo_cnt;
   logic [CW-1:0]      w_tmo_nxt;
   logic               r_hold_valid;
   logic               w_hold_valid_nxt;
   logic [DW-1:0]      r_hold_data;
   logic [DW-1:0]      w_hold_data_nxt;
`endif

   assign w_cand = r_pending | req_stb_i;
   assign w_win  = f_rr_pick(w_cand, r_rr_ptr);

   // Next-state and registered-output decode.
   always_comb begin
      w_state_nxt      = r_state;
      w_rr_ptr_nxt     = r_rr_ptr;
      w_gnt_idx_nxt    = r_gnt_idx;
      w_ack_nxt        = '0;
      w_rx_stb_nxt     = 1'b0;
      w_data_nxt       = r_data;
`ifdef UART_RX_ARB_TIMEOUT_EN
      w_err_nxt        = '0;
      w_tmo_nxt        = r_tmo_cnt;
      w_hold_valid_nxt = r_hold_valid;
      w_hold_data_nxt  = r_hold_data;
`endif
      case (r_state)
         S_IDLE: begin
            if (|w_cand) begin
`ifdef UART_RX_ARB_TIMEOUT_EN
               // A byte recovered from a timed-out read is handed to the next winner.
               if (r_hold_valid) begin
                  w_ack_nxt        = f_onehot(w_win);
                  w_data_nxt       = r_hold_data;
                  w_hold_valid_nxt = 1'b0;
                  w_rr_ptr_nxt     = f_inc(w_win);
               end else
`endif
               begin
                  w_gnt_idx_nxt = w_win;
                  w_rx_stb_nxt  = 1'b1;
                  w_state_nxt   = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
`ifdef UART_RX_ARB_TIMEOUT_EN
            w_tmo_nxt = '0;
`endif
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (rx_ack_i) begin
               w_data_nxt   = rx_data_i;
               w_ack_nxt    = f_onehot(r_gnt_idx);
               w_rr_ptr_nxt = f_inc(r_gnt_idx);
               w_state_nxt  = S_IDLE;
            end
`ifdef UART_RX_ARB_TIMEOUT_EN
            else if (r_tmo_cnt + CW'(1) >= CW'(TIMEOUT_CLKS)) begin
               w_err_nxt    = f_onehot(r_gnt_idx);
               w_rr_ptr_nxt = f_inc(r_gnt_idx);
               w_state_nxt  = S_DRAIN;
            end else begin
               w_tmo_nxt = r_tmo_cnt + CW'(1);
            end
`endif
         end
`ifdef UART_RX_ARB_TIMEOUT_EN
         // The receiver still owes an ack for the abandoned strobe; park its byte.
         S_DRAIN: begin
            if (rx_ack_i) begin
               w_hold_data_nxt  = rx_data_i;
               w_hold_valid_nxt = 1'b1;
               w_state_nxt      = S_IDLE;
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
`ifdef UART_RX_ARB_TIMEOUT_EN
      w_done = w_ack_nxt | w_err_nxt;
`else
      w_done = w_ack_nxt;
`endif
      w_pending_nxt = (r_pending | req_stb_i) & ~w_done;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state      <= S_IDLE;
         r_pending    <= '0;
         r_rr_ptr     <= '0;
         r_gnt_idx    <= '0;
         r_ack        <= '0;
         r_rx_stb     <= 1'b0;
         r_data       <= '0;
`ifdef UART_RX_ARB_TIMEOUT_EN
         r_err        <= '0;
         r_tmo_cnt    <= '0;
         r_hold_valid <= 1'b0;
         r_hold_data  <= '0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_pending    <= w_pending_nxt;
         r_rr_ptr     <= w_rr_ptr_nxt;
         r_gnt_idx    <= w_gnt_idx_nxt;
         r_ack        <= w_ack_nxt;
         r_rx_stb     <= w_rx_stb_nxt;
         r_data       <= w_data_nxt;
`ifdef UART_RX_ARB_TIMEOUT_EN
         r_err        <= w_err_nxt;
         r_tmo_cnt    <= w_tmo_nxt;
         r_hold_valid <= w_hold_valid_nxt;
         r_hold_data  <= w_hold_data_nxt;
`endif
      end
   end

   assign req_ack_o  = r_ack;
   assign rx_stb_o   = r_rx_stb;
   assign req_data_o = r_data;
`ifdef UART_RX_ARB_TIMEOUT_EN
   assign req_err_o  = r_err;
`else
   assign req_err_o  = '0;
`endif

endmodule
